nios_system_pixel_cmd_out: RTL and testbench
============================================

// Module: nios_system_pixel_cmd_out
// PURPOSE
//  CPU-to-fabric counterpart of the pixel input PIOs. Nios II writes pixel X, Y and COLOR
//  over an Avalon-MM slave, then writes GO. The block issues one pixel-write command to the
//  frame-drawing logic over a valid/ready handshake and reports BUSY/DONE/OVERRUN status.
//  It sits between the Avalon interconnect and the paint datapath, on the same clock.
// PARAMETERS
//  X_W      10  width of the pixel X coordinate
//  Y_W      9   width of the pixel Y coordinate
//  COLOR_W  16  width of the pixel colour word
//  CNT_W    16  width of the issued-pixel counter
// PORTS
//  clk         in   1        system clock; single clock domain
//  reset_n     in   1        asynchronous, active-low reset
//  chipselect  in   1        Avalon slave select
//  address     in   3        word address of the register
//  write_n     in   1        active-low write strobe; a write occurs when chipselect & ~write_n
//  writedata   in   32       write data
//  readdata    out  32       registered read data
//  irq         out  1        interrupt = IRQ_EN & DONE
//  px_valid    out  1        command valid
//  px_ready    in   1        command accepted by the consumer
//  px_x        out  X_W      command X coordinate
//  px_y        out  Y_W      command Y coordinate
//  px_color    out  COLOR_W  command colour
// BEHAVIOUR
//  Register map (word address):
//   0 X      RW; writedata[X_W-1:0]
//   1 Y      RW; writedata[Y_W-1:0]
//   2 COLOR  RW; writedata[COLOR_W-1:0]
//   3 CTRL   write: b0 GO (self-clearing), b1 IRQ_EN, b2 write-1-clears DONE,
//            b3 write-1-clears OVERRUN.
//            read: b0 BUSY, b1 IRQ_EN, b2 DONE, b3 OVERRUN.
//   4 COUNT  RO read; any write clears it to 0.
//   5-7      read 0; writes ignored.
//  Reset values: all outputs, staging registers, flags, COUNT and state are 0, and state is IDLE.
//  readdata: updated every clk from the address mux, regardless of chipselect.
//   Read latency is 1 cycle. Unused bits read 0.
//  Staging registers (X, Y, COLOR) are written at any time. Writes during SEND do not change px_*.
//  FSM: IDLE, SEND.
//   IDLE + GO: load px_x/px_y/px_color from the staging registers, or from this cycle's
//    writedata if that staging register is written in the same cycle (it is not, since the
//    addresses differ). Set px_valid=1 on the next edge and go to SEND. BUSY=1 in SEND.
//   SEND with px_valid & px_ready: this is a handshake. COUNT+1 (wraps at 2^CNT_W), set DONE.
//    If GO is written in the same cycle, reload px_* and stay in SEND (back-to-back; no overrun).
//    Otherwise clear px_valid and go to IDLE.
//   SEND + GO without a handshake: GO is dropped, OVERRUN is set, and px_* are unchanged.
//  px_* and px_valid are stable while px_valid=1 and px_ready=0 (AXI-style hold).
//  Flag precedence: a hardware set of DONE or OVERRUN wins over a same-cycle write-1-clear.
//   A COUNT clear in the same cycle as a handshake gives COUNT=0.
//  IRQ_EN, DONE clear and GO in one CTRL write are all honoured together.
//  irq is combinational from registered flags and has no extra latency.
//  An asynchronous reset mid-SEND drops px_valid immediately. The pending command is lost.
// TESTING
//  1 Reset: assert reset_n=0 mid-SEND -> px_valid, readdata, irq, COUNT all 0 at once.
//  2 Single pixel: write X=0x13F, Y=0x0EF, COLOR=0xF800, then GO, with px_ready=1
//    -> px_valid high for 1 cycle with those values; COUNT=1, DONE=1, BUSY=0.
//  3 Backpressure: px_ready=0 for 5 cycles, then write X=5 during the stall
//    -> px_x holds its old value until the handshake; BUSY reads 1 during the stall.
//  4 Overrun: GO while stalled -> OVERRUN=1, only one handshake occurs.
//    Write CTRL=0x8 -> OVERRUN=0.
//  5 Back-to-back: GO in the same cycle as the handshake -> px_valid stays 1,
//    new values appear next cycle, COUNT+2 total, OVERRUN=0.
//  6 IRQ/wrap: IRQ_EN=1 with COUNT preset to 0xFFFF via handshakes -> next handshake gives
//    COUNT=0 and irq=1. DONE clear in the same cycle as a handshake leaves DONE=1.

Source files
------------

// File: rtl/nios_system_pixel_cmd_out_if.sv
// Pixel-write command channel between the CPU-side command block and the paint datapath.
// The master (command source) drives valid and payload; the slave (consumer) drives ready.
interface nios_system_pixel_cmd_out_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 16
);
  logic               px_valid;
  logic               px_ready;
  logic [X_W-1:0]     px_x;
  logic [Y_W-1:0]     px_y;
  logic [COLOR_W-1:0] px_color;

  modport master (
    output px_valid,
    output px_x,
    output px_y,
    output px_color,
    input  px_ready
  );

  modport slave (
    input  px_valid,
    input  px_x,
    input  px_y,
    input  px_color,
    output px_ready
  );
endinterface

// File: rtl/nios_system_pixel_cmd_out.sv
// Avalon-MM slave that stages a pixel (X, Y, COLOR) written by the Nios II and issues it
// as a single valid/ready command on GO, with BUSY/DONE/OVERRUN status and a COUNT register.
module nios_system_pixel_cmd_out #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  nios_system_pixel_cmd_out_if.master px
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [X_W-1:0]     x_stage;
  logic [Y_W-1:0]     y_stage;
  logic [COLOR_W-1:0] color_stage;
  logic [CNT_W-1:0]   count;
  logic               irq_en;
  logic               done;
  logic               overrun;

  logic        wr;
  logic        wr_ctrl;
  logic        wr_count;
  logic        go;
  logic        handshake;
  logic [31:0] rd_mux;
  logic        unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 3'd3);
  assign wr_count  = wr && (address == 3'd4);
  assign go        = wr_ctrl & writedata[0];
  assign handshake = px.px_valid & px.px_ready;
  assign irq       = irq_en & done;
  assign unused_wd = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = 32'(x_stage);
      3'd1:    rd_mux = 32'(y_stage);
      3'd2:    rd_mux = 32'(color_stage);
      3'd3:    rd_mux = {28'd0, overrun, done, irq_en, (state == SEND)};
      3'd4:    rd_mux = 32'(count);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x_stage     <= '0;
      y_stage     <= '0;
      color_stage <= '0;
      count       <= '0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      readdata    <= '0;
      px.px_valid <= 1'b0;
      px.px_x     <= '0;
      px.px_y     <= '0;
      px.px_color <= '0;
    end else begin
      readdata <= rd_mux;

      if (wr && (address == 3'd0)) x_stage     <= writedata[X_W-1:0];
      if (wr && (address == 3'd1)) y_stage     <= writedata[Y_W-1:0];
      if (wr && (address == 3'd2)) color_stage <= writedata[COLOR_W-1:0];
      if (wr_ctrl)                 irq_en      <= writedata[1];

      // Hardware set of a flag takes priority over a same-cycle write-1-clear.
      if (handshake)                     done <= 1'b1;
      else if (wr_ctrl && writedata[2])  done <= 1'b0;

      if (go && (state == SEND) && !handshake) overrun <= 1'b1;
      else if (wr_ctrl && writedata[3])        overrun <= 1'b0;

      if (wr_count)       count <= '0;
      else if (handshake) count <= count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (go) begin
            px.px_x     <= x_stage;
            px.px_y     <= y_stage;
            px.px_color <= color_stage;
            px.px_valid <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (go) begin
              px.px_x     <= x_stage;
              px.px_y     <= y_stage;
              px.px_color <= color_stage;
            end else begin
              px.px_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_pixel_cmd_out.sv
// Directed bench for the pixel command block: reset, single pixel, backpressure,
// overrun, back-to-back issue, counter wrap and IRQ/flag precedence.
`timescale 1ns/1ps
module tb_nios_system_pixel_cmd_out;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  nios_system_pixel_cmd_out_if #(.X_W(10), .Y_W(9), .COLOR_W(16)) px_if ();

  nios_system_pixel_cmd_out #(.X_W(10), .Y_W(9), .COLOR_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .px         (px_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic avl_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; address = a; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic avl_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; address = a; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    #23;
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", px_if.px_valid); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %0h want 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0h want 0", irq); end
    @(negedge clk); reset_n = 1'b1;
    px_if.px_ready = 1'b0;
    avl_write(3'd0, 32'h2A);
    avl_write(3'd3, 32'h3);
    checks++; if (px_if.px_valid !== 1'b1) begin errors++; $display("FAIL rst_send_valid: got %0h want 1", px_if.px_valid); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0h want 0", px_if.px_valid); end
    checks++; if (px_if.px_x !== 10'h0) begin errors++; $display("FAIL rst_mid_x: got %0h want 0", px_if.px_x); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_mid_readdata: got %0h want 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq: got %0h want 0", irq); end
    @(negedge clk); reset_n = 1'b1;
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_count: got %0h want 0", rd); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %0h want 0", rd); end
    avl_read(3'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_xreg: got %0h want 0", rd); end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    px_if.px_ready = 1'b1;
    avl_write(3'd0, 32'h13F);
    avl_write(3'd1, 32'h0EF);
    avl_write(3'd2, 32'hF800);
    avl_write(3'd3, 32'h1);
    checks++; if (px_if.px_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h want 1", px_if.px_valid); end
    checks++; if (px_if.px_x !== 10'h13F) begin errors++; $display("FAIL single_x: got %0h want 13f", px_if.px_x); end
    checks++; if (px_if.px_y !== 9'h0EF) begin errors++; $display("FAIL single_y: got %0h want ef", px_if.px_y); end
    checks++; if (px_if.px_color !== 16'hF800) begin errors++; $display("FAIL single_color: got %0h want f800", px_if.px_color); end
    @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %0h want 0", px_if.px_valid); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL single_count: got %0h want 1", rd); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL single_ctrl: got %0h want 4", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq: got %0h want 0", irq); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    px_if.px_ready = 1'b0;
    avl_write(3'd3, 32'h5);
    avl_write(3'd0, 32'h5);
    repeat (2) @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %0h want 1", px_if.px_valid); end
    checks++; if (px_if.px_x !== 10'h13F) begin errors++; $display("FAIL bp_x_hold: got %0h want 13f", px_if.px_x); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL bp_ctrl_busy: got %0h want 1", rd); end
    avl_read(3'd0, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL bp_xreg: got %0h want 5", rd); end
    checks++; if (px_if.px_x !== 10'h13F) begin errors++; $display("FAIL bp_x_hold2: got %0h want 13f", px_if.px_x); end
    px_if.px_ready = 1'b1;
    @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %0h want 0", px_if.px_valid); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL bp_count: got %0h want 2", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    px_if.px_ready = 1'b0;
    avl_write(3'd3, 32'h5);
    checks++; if (px_if.px_x !== 10'h5) begin errors++; $display("FAIL ovr_x: got %0h want 5", px_if.px_x); end
    avl_write(3'd0, 32'h7);
    avl_write(3'd3, 32'h1);
    checks++; if (px_if.px_x !== 10'h5) begin errors++; $display("FAIL ovr_x_unchanged: got %0h want 5", px_if.px_x); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL ovr_ctrl_set: got %0h want 9", rd); end
    px_if.px_ready = 1'b1;
    @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %0h want 0", px_if.px_valid); end
    repeat (3) @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL ovr_no_second: got %0h want 0", px_if.px_valid); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL ovr_count: got %0h want 3", rd); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'hC) begin errors++; $display("FAIL ovr_ctrl_after: got %0h want c", rd); end
    avl_write(3'd3, 32'h8);
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL ovr_clear: got %0h want 4", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    px_if.px_ready = 1'b0;
    avl_write(3'd0, 32'h10);
    avl_write(3'd1, 32'h20);
    avl_write(3'd2, 32'h1234);
    avl_write(3'd3, 32'h1);
    avl_write(3'd0, 32'h11);
    avl_write(3'd1, 32'h21);
    avl_write(3'd2, 32'h5678);
    checks++; if (px_if.px_x !== 10'h10) begin errors++; $display("FAIL b2b_first_x: got %0h want 10", px_if.px_x); end
    checks++; if (px_if.px_color !== 16'h1234) begin errors++; $display("FAIL b2b_first_color: got %0h want 1234", px_if.px_color); end
    @(negedge clk);
    px_if.px_ready = 1'b1;
    chipselect = 1'b1; address = 3'd3; write_n = 1'b0; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    checks++; if (px_if.px_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_stay: got %0h want 1", px_if.px_valid); end
    checks++; if (px_if.px_x !== 10'h11) begin errors++; $display("FAIL b2b_second_x: got %0h want 11", px_if.px_x); end
    checks++; if (px_if.px_y !== 9'h21) begin errors++; $display("FAIL b2b_second_y: got %0h want 21", px_if.px_y); end
    checks++; if (px_if.px_color !== 16'h5678) begin errors++; $display("FAIL b2b_second_color: got %0h want 5678", px_if.px_color); end
    @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %0h want 0", px_if.px_valid); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL b2b_count: got %0h want 5", rd); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL b2b_ctrl: got %0h want 4", rd); end
  endtask

  task automatic test_irq_wrap();
    logic [31:0] rd;
    avl_write(3'd4, 32'h0);
    avl_write(3'd3, 32'h6);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_cleared: got %0h want 0", irq); end
    // Holding GO for N cycles with ready high yields exactly N handshakes.
    @(negedge clk);
    px_if.px_ready = 1'b1;
    chipselect = 1'b1; address = 3'd3; write_n = 1'b0; writedata = 32'h3;
    repeat (65535) @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    checks++; if (px_if.px_valid !== 1'b0) begin errors++; $display("FAIL wrap_burst_end: got %0h want 0", px_if.px_valid); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'hFFFF) begin errors++; $display("FAIL wrap_preset: got %0h want ffff", rd); end
    avl_write(3'd3, 32'h6);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_pre: got %0h want 0", irq); end
    avl_write(3'd3, 32'h3);
    checks++; if (px_if.px_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0h want 1", px_if.px_valid); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wrap_irq: got %0h want 1", irq); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_count: got %0h want 0", rd); end

    px_if.px_ready = 1'b0;
    avl_write(3'd3, 32'h7);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prec_irq_low: got %0h want 0", irq); end
    @(negedge clk);
    px_if.px_ready = 1'b1;
    chipselect = 1'b1; address = 3'd3; write_n = 1'b0; writedata = 32'h6;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prec_done_wins: got %0h want 1", irq); end
    avl_read(3'd3, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL prec_ctrl: got %0h want 6", rd); end
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL prec_count: got %0h want 1", rd); end

    px_if.px_ready = 1'b0;
    avl_write(3'd3, 32'h3);
    @(negedge clk);
    px_if.px_ready = 1'b1;
    chipselect = 1'b1; address = 3'd4; write_n = 1'b0; writedata = 32'h0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    avl_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prec_count_clear: got %0h want 0", rd); end
    avl_read(3'd5, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unused_addr: got %0h want 0", rd); end
  endtask

  initial begin
    reset_n        = 1'b0;
    chipselect     = 1'b0;
    address        = 3'd0;
    write_n        = 1'b1;
    writedata      = 32'h0;
    px_if.px_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_irq_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
